// File: rtl/pio_multi_pwm_driver.sv
// Loads a PIO program and configuration image, then feeds duty values to per-SM TX FIFOs.
// Registered outputs, one operation per cycle; duty_ready is high only in RUN, pushes wait on full.
module pio_multi_pwm_driver #(
  parameter int PROG_LEN = 32,
  parameter int CONF_LEN = 11,
  parameter int NUM_SM   = 4,
  parameter int VAL_W    = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  output logic [4:0]       prog_addr,
  input  logic [15:0]      prog_data,
  output logic [4:0]       conf_addr,
  input  logic [37:0]      conf_data,
  input  logic             duty_valid,
  output logic             duty_ready,
  input  logic [1:0]       duty_ch,
  input  logic [VAL_W-1:0] duty_val,
  input  logic [3:0]       full,
  output logic [3:0]       action,
  output logic [31:0]      din,
  output logic [4:0]       index,
  output logic [1:0]       mindex,
  output logic             running,
  output logic             overwrite
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CONF = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam logic [4:0] PROG_LAST = 5'(PROG_LEN - 1);
  localparam logic [4:0] CONF_LAST = 5'(CONF_LEN - 1);
  localparam logic [3:0] ACT_NOP   = 4'd0;
  localparam logic [3:0] ACT_INSTR = 4'd1;
  localparam logic [3:0] ACT_PUSH  = 4'd4;

  state_t           state, state_nxt;
  logic [4:0]       cnt, cnt_nxt;

  logic [3:0]       pending;
  logic [VAL_W-1:0] hold [4];
  logic [1:0]       ptr;
  logic             last_vld;
  logic [1:0]       last_ch;

  logic             push_vld;
  logic [1:0]       push_ch;
  logic             wr_acc;

  function automatic logic [1:0] rr_ch(input logic [1:0] base, input int offs);
    return 2'((int'(base) + offs) % NUM_SM);
  endfunction

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (start) begin
      state_nxt = LOAD;
      cnt_nxt   = '0;
    end else begin
      case (state)
        LOAD: begin
          if (cnt == PROG_LAST) begin
            state_nxt = CONF;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 5'd1;
          end
        end
        CONF: begin
          if (cnt == CONF_LAST) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Round-robin from ptr; the channel pushed last cycle is skipped because its full flag lags by one.
  always_comb begin
    push_vld = 1'b0;
    push_ch  = '0;
    for (int i = 0; i < NUM_SM; i++) begin
      if (!push_vld && pending[rr_ch(ptr, i)] && !full[rr_ch(ptr, i)] &&
          !(last_vld && last_ch == rr_ch(ptr, i))) begin
        push_vld = 1'b1;
        push_ch  = rr_ch(ptr, i);
      end
    end
    if (state != RUN || start) push_vld = 1'b0;
  end

  assign wr_acc = duty_valid && duty_ready && (state == RUN) && !start &&
                  (int'(duty_ch) < NUM_SM);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      prog_addr  <= '0;
      conf_addr  <= '0;
      action     <= ACT_NOP;
      din        <= '0;
      index      <= '0;
      mindex     <= '0;
      running    <= 1'b0;
      duty_ready <= 1'b0;
      overwrite  <= 1'b0;
      pending    <= '0;
      ptr        <= '0;
      last_vld   <= 1'b0;
      last_ch    <= '0;
      for (int i = 0; i < 4; i++) hold[i] <= '0;
    end else begin
      action     <= ACT_NOP;
      overwrite  <= 1'b0;
      prog_addr  <= (state_nxt == LOAD) ? cnt_nxt : 5'd0;
      conf_addr  <= (state_nxt == CONF) ? cnt_nxt : 5'd0;
      running    <= (state_nxt == RUN);
      duty_ready <= (state_nxt == RUN);
      if (start) begin
        pending  <= '0;
        ptr      <= '0;
        last_vld <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            action <= ACT_INSTR;
            din    <= {16'b0, prog_data};
            index  <= cnt;
            mindex <= '0;
          end
          CONF: begin
            action <= conf_data[35:32];
            din    <= conf_data[31:0];
            index  <= '0;
            mindex <= conf_data[37:36];
          end
          RUN: begin
            last_vld <= push_vld;
            last_ch  <= push_ch;
            if (push_vld) begin
              action           <= ACT_PUSH;
              din              <= 32'(hold[push_ch]);
              index            <= '0;
              mindex           <= push_ch;
              pending[push_ch] <= 1'b0;
              ptr              <= rr_ch(push_ch, 1);
            end
            // A write landing on the channel being pushed re-arms pending and is not an overwrite.
            if (wr_acc) begin
              hold[duty_ch]    <= duty_val;
              pending[duty_ch] <= 1'b1;
              overwrite        <= pending[duty_ch] && !(push_vld && push_ch == duty_ch);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pio_multi_pwm_driver.sv
// Directed bench for pio_multi_pwm_driver: load/config sequence, push arbitration, restart and reset.
module tb_pio_multi_pwm_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_reset, start, duty_valid;
  logic [1:0]  duty_ch;
  logic [7:0]  duty_val;
  logic [3:0]  full;
  logic [4:0]  prog_addr, conf_addr, index;
  logic [15:0] prog_data;
  logic [37:0] conf_data;
  logic        duty_ready, running, overwrite;
  logic [3:0]  action;
  logic [31:0] din;
  logic [1:0]  mindex;

  logic        start2, duty_valid2;
  logic [1:0]  duty_ch2;
  logic [7:0]  duty_val2;
  logic [3:0]  full2;
  logic [4:0]  prog_addr2, conf_addr2, index2;
  logic [15:0] prog_data2;
  logic [37:0] conf_data2;
  logic        duty_ready2, running2, overwrite2;
  logic [3:0]  action2;
  logic [31:0] din2;
  logic [1:0]  mindex2;

  function automatic logic [15:0] prog_word(input logic [4:0] a);
    return 16'hA000 ^ {3'b0, a, 3'b0, a};
  endfunction

  function automatic logic [37:0] conf_word(input logic [4:0] a);
    return {a[1:0], 1'b1, a[2:0], 32'hC0DE_0000 | {27'b0, a}};
  endfunction

  assign prog_data  = prog_word(prog_addr);
  assign conf_data  = conf_word(conf_addr);
  assign prog_data2 = prog_word(prog_addr2);
  assign conf_data2 = conf_word(conf_addr2);

  pio_multi_pwm_driver #(.PROG_LEN(32), .CONF_LEN(11), .NUM_SM(4), .VAL_W(8)) u_dut (
    .clk(clk), .n_reset(n_reset), .start(start),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .conf_addr(conf_addr), .conf_data(conf_data),
    .duty_valid(duty_valid), .duty_ready(duty_ready), .duty_ch(duty_ch), .duty_val(duty_val),
    .full(full), .action(action), .din(din), .index(index), .mindex(mindex),
    .running(running), .overwrite(overwrite)
  );

  pio_multi_pwm_driver #(.PROG_LEN(2), .CONF_LEN(1), .NUM_SM(2), .VAL_W(8)) u_dut2 (
    .clk(clk), .n_reset(n_reset), .start(start2),
    .prog_addr(prog_addr2), .prog_data(prog_data2),
    .conf_addr(conf_addr2), .conf_data(conf_data2),
    .duty_valid(duty_valid2), .duty_ready(duty_ready2), .duty_ch(duty_ch2), .duty_val(duty_val2),
    .full(full2), .action(action2), .din(din2), .index(index2), .mindex(mindex2),
    .running(running2), .overwrite(overwrite2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int ow_cnt, ow2_cnt;
  logic [33:0] push_q[$];
  int          push_t[$];
  logic [33:0] push2_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (action == 4'd4) begin
      push_q.push_back({mindex, din});
      push_t.push_back(cyc);
    end
    if (overwrite) ow_cnt++;
    if (action2 == 4'd4) push2_q.push_back({mindex2, din2});
    if (overwrite2) ow2_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    push_q.delete();
    push_t.delete();
    push2_q.delete();
    ow_cnt  = 0;
    ow2_cnt = 0;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] v);
    duty_valid = 1'b1;
    duty_ch    = ch;
    duty_val   = v;
    tick();
    duty_valid = 1'b0;
  endtask

  task automatic wr2(input logic [1:0] ch, input logic [7:0] v);
    duty_valid2 = 1'b1;
    duty_ch2    = ch;
    duty_val2   = v;
    tick();
    duty_valid2 = 1'b0;
  endtask

  function automatic logic [33:0] q_at(input int i);
    if (i < push_q.size()) return push_q[i];
    return '1;
  endfunction

  function automatic logic [33:0] q2_at(input int i);
    if (i < push2_q.size()) return push2_q[i];
    return '1;
  endfunction

  initial begin
    logic [37:0] cw;
    int gap;
    n_reset = 1'b0; start = 1'b0; duty_valid = 1'b0; duty_ch = '0; duty_val = '0; full = '0;
    start2 = 1'b0; duty_valid2 = 1'b0; duty_ch2 = '0; duty_val2 = '0; full2 = '0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_action", action, 0);
    chk("rst_din", din, 0);
    chk("rst_index", index, 0);
    chk("rst_mindex", mindex, 0);
    chk("rst_prog_addr", prog_addr, 0);
    chk("rst_conf_addr", conf_addr, 0);
    chk("rst_running", running, 0);
    chk("rst_ready", duty_ready, 0);
    chk("rst_overwrite", overwrite, 0);
    n_reset = 1'b1;

    // Idle: no self-start, duty writes ignored
    duty_valid = 1'b1; duty_ch = 2'd0; duty_val = 8'hEE;
    ticks(3);
    chk("idle_ready", duty_ready, 0);
    chk("idle_action", action, 0);
    chk("idle_running", running, 0);
    duty_valid = 1'b0;

    // Full load and configuration
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_gap_action", action, 0);
    for (int k = 0; k < 32; k++) begin
      tick();
      chk($sformatf("load_act[%0d]", k), action, 1);
      chk($sformatf("load_idx[%0d]", k), index, k);
      chk($sformatf("load_din[%0d]", k), din, {16'b0, prog_word(5'(k))});
      chk($sformatf("load_mindex[%0d]", k), mindex, 0);
    end
    for (int j = 0; j < 11; j++) begin
      tick();
      cw = conf_word(5'(j));
      chk($sformatf("conf_act[%0d]", j), action, cw[35:32]);
      chk($sformatf("conf_din[%0d]", j), din, cw[31:0]);
      chk($sformatf("conf_mindex[%0d]", j), mindex, cw[37:36]);
      chk($sformatf("conf_running[%0d]", j), running, (j == 10) ? 1 : 0);
    end
    clr();
    tick();
    chk("run_nop", action, 0);
    chk("run_ready", duty_ready, 1);

    // Single write to ch2
    wr(2'd2, 8'h40);
    tick();
    chk("t2_act", action, 4);
    chk("t2_mindex", mindex, 2);
    chk("t2_din", din, 32'h40);
    ticks(6);
    chk("t2_count", push_q.size(), 1);
    chk("t2_ow", ow_cnt, 0);

    // Burst to ch0, ch1, ch3
    clr();
    wr(2'd0, 8'h11);
    wr(2'd1, 8'h22);
    wr(2'd3, 8'h33);
    ticks(5);
    chk("t3_count", push_q.size(), 3);
    chk("t3_push0", q_at(0), {2'd0, 32'h11});
    chk("t3_push1", q_at(1), {2'd1, 32'h22});
    chk("t3_push2", q_at(2), {2'd3, 32'h33});
    chk("t3_ow", ow_cnt, 0);

    // Overwrite while FIFO full
    clr();
    full = 4'b0010;
    wr(2'd1, 8'h10);
    wr(2'd1, 8'h20);
    ticks(3);
    chk("t4_ow", ow_cnt, 1);
    chk("t4_nopush", push_q.size(), 0);
    full = 4'b0000;
    ticks(4);
    chk("t4_count", push_q.size(), 1);
    chk("t4_push", q_at(0), {2'd1, 32'h20});
    chk("t4_ow_after", ow_cnt, 1);

    // Write colliding with a push on the same channel
    clr();
    wr(2'd0, 8'h50);
    wr(2'd0, 8'h60);
    ticks(4);
    chk("t5_count", push_q.size(), 2);
    chk("t5_old", q_at(0), {2'd0, 32'h50});
    chk("t5_new", q_at(1), {2'd0, 32'h60});
    gap = (push_t.size() > 1) ? push_t[1] - push_t[0] : -1;
    chk("t5_gap", gap, 2);
    chk("t5_ow", ow_cnt, 0);

    // Restart from RUN with a pending value, then again mid-CONF
    clr();
    full = 4'b0001;
    wr(2'd0, 8'h99);
    tick();
    chk("t6_held", push_q.size(), 0);
    full = 4'b0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_suppress", action, 0);
    chk("t6_running", running, 0);
    chk("t6_ready", duty_ready, 0);
    ticks(35);
    cw = conf_word(5'd2);
    chk("t6_in_conf", action, cw[35:32]);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_conf_suppress", action, 0);
    tick();
    chk("t6_reload_act", action, 1);
    chk("t6_reload_idx", index, 0);
    chk("t6_reload_din", din, {16'b0, prog_word(5'd0)});
    ticks(42);
    chk("t6_run_again", running, 1);
    clr();
    ticks(8);
    chk("t6_no_stale", push_q.size(), 0);
    chk("t6_ow", ow_cnt, 0);

    // Two-channel instance: out-of-range channels dropped
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    ticks(3);
    chk("t7_running", running2, 1);
    clr();
    wr2(2'd3, 8'h77);
    wr2(2'd3, 8'h78);
    wr2(2'd2, 8'h79);
    ticks(4);
    chk("t7_nopush", push2_q.size(), 0);
    chk("t7_ow", ow2_cnt, 0);
    wr2(2'd1, 8'h5A);
    ticks(3);
    chk("t7_count", push2_q.size(), 1);
    chk("t7_push", q2_at(0), {2'd1, 32'h5A});

    // Asynchronous reset mid-LOAD
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(5);
    chk("t8_loading", action, 1);
    #2;
    n_reset = 1'b0;
    #1;
    chk("t8_rst_action", action, 0);
    chk("t8_rst_addr", prog_addr, 0);
    chk("t8_rst_index", index, 0);
    chk("t8_rst_running2", running2, 0);
    n_reset = 1'b1;
    ticks(3);
    chk("t8_idle_action", action, 0);
    chk("t8_idle_addr", prog_addr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pio_multi_pwm_driver.md
Name: pio_multi_pwm_driver

Overview:
Parametrised PIO bring-up and run-time feeder for PWM programs.
- Streams a program image and a per-state-machine configuration image into one pio instance.
- In run mode, accepts duty values for up to NUM_SM channels from a valid/ready source and pushes each to the matching state machine's TX FIFO, honouring the FIFO full flags.
- Sits between the board top and the pio core, replacing hand-coded loader/feeder logic in each top.

Parameters:
PROG_LEN, 32, number of instruction words loaded (1..32).
CONF_LEN, 11, number of configuration words issued (1..32).
NUM_SM, 4, number of state machines/channels served (1..4).
VAL_W, 8, duty value width; zero-extended onto din.

Ports:
clk  in  1  system clock
n_reset  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; (re)starts load sequence from any state
prog_addr  out  5  program image address
prog_data  in  16  program word at prog_addr (combinational read)
conf_addr  out  5  config image address
conf_data  in  38  config word: [37:36] mindex, [35:32] action, [31:0] data
duty_valid  in  1  duty value offered
duty_ready  out  1  duty value accepted this cycle when high with duty_valid
duty_ch  in  2  target channel
duty_val  in  VAL_W  duty value
full  in  4  pio TX FIFO full per state machine
action  out  4  pio action (0 nop, 1 write instruction, 4 push, others from config)
din  out  32  pio data
index  out  5  pio instruction index
mindex  out  2  pio machine index
running  out  1  high in RUN state
overwrite  out  1  one-cycle pulse: a pending duty value was replaced before being pushed

Behaviour:
- Reset (async assert, sync deassert handled by the top): state=IDLE, action=0, din=0, index=0, mindex=0, prog_addr=0, conf_addr=0, running=0, overwrite=0, all pending bits=0.
- All outputs are registered. action is a one-cycle pulse per issued operation.
- IDLE: on start go to LOAD with counter=0. With no start, stays IDLE. The block never self-starts after reset.
- LOAD: each cycle issues action=1, din={16'b0,prog_data}, index=counter, mindex=0, with prog_addr=counter. After counter==PROG_LEN-1 is issued, go to CONF with counter=0. Exactly PROG_LEN writes are issued, on consecutive cycles.
- CONF: each cycle issues action=conf_data[35:32], din=conf_data[31:0], mindex=conf_data[37:36], with conf_addr=counter. After counter==CONF_LEN-1, go to RUN; the next cycle has action=0.
- RUN: running=1; duty_ready=1.
  - Accepted writes with duty_ch>=NUM_SM are discarded silently.
  - Each channel has a VAL_W holding register and a pending bit.
  - On an accepted write to a pending channel, the value is replaced (latest wins) and overwrite pulses the next cycle.
- Push arbiter: round-robin pointer over channels 0..NUM_SM-1.
  - Each cycle, select the first channel from the pointer with pending=1, full[ch]=0, and ch not pushed in the previous cycle. The last rule covers the one-cycle lag of full.
  - For the selected channel, issue action=4, mindex=ch, din=zero-extended value; clear pending; set pointer to ch+1 (wrapping).
  - At most one push per cycle. Otherwise action=0.
- Simultaneous write and push on the same channel:
  - The push carries the old value.
  - The new value is left pending.
  - No overwrite pulse.
- start in any state, including mid-LOAD, CONF or RUN:
  - Next cycle enters LOAD at counter 0.
  - Pending bits are cleared and running=0.
  - Any in-flight action that cycle is suppressed (action=0).
- duty_ready=0 outside RUN; duty_valid is ignored there.
- Asserting n_reset mid-operation returns to IDLE immediately.

Test Plan:
- Reset, start, PROG_LEN=32, CONF_LEN=11 -> 32 consecutive action=1 with index 0..31 and din matching prog_data, then 11 config actions with conf-supplied mindex, then running=1 at cycle 44 after start.
- RUN, write ch2=0x40, full=0 -> one action=4, mindex=2, din=0x40 within 2 cycles; no further pushes.
- Writes to ch0, ch1, ch3 in one burst -> pushes in order 0,1,3 on non-consecutive-same-channel cycles, each exactly once.
- full[1]=1, ch1=0x10 then 0x20 written -> overwrite pulses once, no push while full; full[1] falls -> single push din=0x20.
- NUM_SM=2, write duty_ch=3 -> no push, no overwrite.
- start pulse mid-CONF with ch0 pending -> action=0 that cycle, reload from index 0, pending cleared, no stale push after RUN.
